// File: rtl/dht_transaction_ctrl.sv
// Single-wire DHT11/DHT22 transaction controller: host start pulse, response check,
// timed bit capture with checksum, per-phase timeouts and an enforced inter-transaction gap.
module dht_transaction_ctrl #(
    parameter int unsigned TICKS_PER_US    = 1,
    parameter int unsigned START_LOW_US    = 18000,
    parameter int unsigned RESP_TIMEOUT_US = 200,
    parameter int unsigned BIT_TIMEOUT_US  = 100,
    parameter int unsigned BIT_THRESH_US   = 50,
    parameter int unsigned NUM_BITS        = 40,
    parameter int unsigned CHECKSUM_EN     = 1,
    parameter int unsigned MIN_GAP_US      = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    inout  wire logic           dht_data,
    output logic                busy,
    output logic                data_valid,
    output logic [NUM_BITS-1:0] data_out,
    output logic                chk_ok,
    output logic                error,
    output logic [1:0]          err_code
);

    localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    typedef enum logic [3:0] {
        IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH,
        BIT_LOW, BIT_HIGH, DONE, ERROR, GAP
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       pre_cnt_q, pre_cnt_d;
    logic [20:0]         us_cnt_q, us_cnt_d;
    logic [2:0]          sync_q, sync_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [NUM_BITS-1:0] data_out_q, data_out_d;
    logic                chk_ok_q, chk_ok_d;
    logic                busy_q, busy_d;
    logic [1:0]          err_code_q, err_code_d;

    logic                us_tick, rise, fall, drive_low;
    logic [20:0]         us_elapsed;
    logic [NUM_BITS-1:0] shift_next;

    function automatic logic frame_chk(input logic [NUM_BITS-1:0] f);
        logic [39:0] f40;
        logic [7:0]  sum;
        f40 = 40'(f);
        sum = f40[39:32] + f40[31:24] + f40[23:16] + f40[15:8];
        if (CHECKSUM_EN == 0 || NUM_BITS != 40) frame_chk = 1'b1;
        else                                    frame_chk = (sum == f40[7:0]);
    endfunction

    // us_elapsed counts the tick landing this cycle, so a compare against N ends a phase after N us
    assign us_tick    = (pre_cnt_q == PW'(TICKS_PER_US - 1));
    assign us_elapsed = us_cnt_q + 21'(us_tick);
    assign rise       = sync_q[1] & ~sync_q[2];
    assign fall       = ~sync_q[1] & sync_q[2];
    assign shift_next = {shift_q[NUM_BITS-2:0], (us_cnt_q > 21'(BIT_THRESH_US))};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            us_cnt_q   <= '0;
            sync_q     <= 3'b111;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            chk_ok_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            us_cnt_q   <= us_cnt_d;
            sync_q     <= sync_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            chk_ok_q   <= chk_ok_d;
            busy_q     <= busy_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[1:0], dht_data};
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        chk_ok_d   = chk_ok_q;
        busy_d     = busy_q;
        err_code_d = err_code_q;
        pre_cnt_d  = pre_cnt_q;
        us_cnt_d   = us_cnt_q;

        case (state_q)
            IDLE: if (start && !busy_q) begin
                state_d    = START_LOW;
                busy_d     = 1'b1;
                err_code_d = 2'd0;
                bit_cnt_d  = '0;
            end
            START_LOW: if (us_elapsed == 21'(START_LOW_US)) state_d = RELEASE;
            RELEASE: begin
                if (fall) state_d = RESP_LOW;
                else if (us_elapsed == 21'(RESP_TIMEOUT_US)) begin
                    state_d    = ERROR;
                    err_code_d = 2'd1;
                end
            end
            RESP_LOW: begin
                if (rise) state_d = RESP_HIGH;
                else if (us_elapsed == 21'(RESP_TIMEOUT_US)) begin
                    state_d    = ERROR;
                    err_code_d = 2'd2;
                end
            end
            RESP_HIGH: begin
                if (fall) state_d = BIT_LOW;
                else if (us_elapsed == 21'(RESP_TIMEOUT_US)) begin
                    state_d    = ERROR;
                    err_code_d = 2'd2;
                end
            end
            BIT_LOW: begin
                if (rise) state_d = BIT_HIGH;
                else if (us_elapsed == 21'(BIT_TIMEOUT_US)) begin
                    state_d    = ERROR;
                    err_code_d = 2'd3;
                end
            end
            BIT_HIGH: begin
                if (fall) begin
                    shift_d = shift_next;
                    if (bit_cnt_q == BW'(NUM_BITS - 1)) begin
                        state_d    = DONE;
                        data_out_d = shift_next;
                        chk_ok_d   = frame_chk(shift_next);
                    end else begin
                        state_d   = BIT_LOW;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else if (us_elapsed == 21'(BIT_TIMEOUT_US)) begin
                    state_d    = ERROR;
                    err_code_d = 2'd3;
                end
            end
            DONE:  state_d = GAP;
            ERROR: state_d = GAP;
            GAP: if (MIN_GAP_US == 0 || us_elapsed == 21'(MIN_GAP_US)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            pre_cnt_d = '0;
            us_cnt_d  = '0;
        end else if (state_q != IDLE) begin
            pre_cnt_d = us_tick ? '0 : pre_cnt_q + PW'(1);
            us_cnt_d  = us_elapsed;
        end
    end

    always_comb begin
        drive_low  = (state_q == START_LOW);
        data_valid = (state_q == DONE);
        error      = (state_q == ERROR);
    end

    assign dht_data = drive_low ? 1'b0 : 1'bz;
    assign busy     = busy_q;
    assign data_out = data_out_q;
    assign chk_ok   = chk_ok_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_dht_transaction_ctrl.sv
// Bench for dht_transaction_ctrl: behavioural DHT sensor on a pulled-up line, scoreboard of
// expected data_valid/error pulses, plus direct checks of start pulse, timeouts and reset.
module tb_dht_transaction_ctrl;

    localparam int START_US = 18000;
    localparam int RESP_TO  = 200;

    typedef struct {
        bit          is_err;
        logic [39:0] data;
        bit          chk;
        logic [1:0]  code;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        sens_low, sens_high, sens_abort;
    int          cur_bit;
    wire         dht_line;
    logic        busy, data_valid, chk_ok, error;
    logic [39:0] data_out;
    logic [1:0]  err_code;

    int          n_vec = 0, n_fail = 0;
    int          cyc = 0;
    int          run = 0, last_run = 0, pulses = 0;
    int          last_err_cyc = -1;
    exp_t        sb[$];

    logic [39:0] model_data = '0;
    bit          model_chk  = 1'b0;

    pullup (dht_line);
    assign dht_line = sens_low ? 1'b0 : 1'bz;

    dht_transaction_ctrl #(
        .TICKS_PER_US(1), .START_LOW_US(START_US), .RESP_TIMEOUT_US(RESP_TO),
        .BIT_TIMEOUT_US(100), .BIT_THRESH_US(50), .NUM_BITS(40),
        .CHECKSUM_EN(1), .MIN_GAP_US(10)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dht_data(dht_line),
        .busy(busy), .data_valid(data_valid), .data_out(data_out),
        .chk_ok(chk_ok), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n && !sens_abort; k++) tick();
    endtask

    task automatic wait_line(input logic v, input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (dht_line === v) return;
        end
        n_vec++;
        n_fail++;
        $display("FAIL wait_line: line never reached %0b within %0d cycles", v, budget);
    endtask

    task automatic wait_idle(input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy) begin
                at = cyc;
                return;
            end
        end
        n_vec++;
        n_fail++;
        $display("FAIL wait_idle: busy still high after %0d cycles", budget);
    endtask

    function automatic bit model_checksum(input logic [39:0] f);
        int s;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        return (s % 256) == int'(f[7:0]);
    endfunction

    task automatic push_valid(input logic [39:0] f);
        exp_t e;
        model_data = f;
        model_chk  = model_checksum(f);
        e.is_err = 1'b0; e.data = f; e.chk = model_chk; e.code = 2'd0;
        sb.push_back(e);
    endtask

    task automatic push_error(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1; e.data = model_data; e.chk = model_chk; e.code = code;
        sb.push_back(e);
    endtask

    // Sensor: wait for the host pulse, answer 80/80 us, then send nbits bits MSB first
    task automatic sensor_txn(input logic [39:0] frame, input int nbits, input bit respond);
        wait_line(1'b0, 100);
        wait_line(1'b1, START_US + 100);
        if (!respond) return;
        hold($urandom_range(20, 40));
        sens_low = 1'b1; hold(80);
        sens_low = 1'b0; hold(80);
        for (int i = 0; i < nbits && !sens_abort; i++) begin
            cur_bit   = i;
            sens_high = 1'b0;
            sens_low  = 1'b1; hold(50);
            sens_low  = 1'b0;
            sens_high = 1'b1; hold(frame[39-i] ? 70 : 26);
        end
        sens_high = 1'b0;
        if (nbits == 40 && !sens_abort) begin
            sens_low = 1'b1; hold(50);
        end
        sens_low = 1'b0;
        cur_bit  = -1;
    endtask

    task automatic start_txn(output int start_cyc);
        tick();
        check("line_idle_before_start", 64'(dht_line), 64'(1));
        start     = 1'b1;
        start_cyc = cyc + 1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_latency_line_low", 64'(dht_line), 64'(0));
        check("busy_after_start", 64'(busy), 64'(1));
    endtask

    always @(negedge clk) begin
        if (!rst) run = 0;
        else if (dht_line === 1'b0 && !sens_low) run++;
        else if (run > 0) begin
            last_run = run;
            pulses++;
            run = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && (data_valid || error)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_pulse: data_valid=%0b error=%0b, required none", data_valid, error);
            end else begin
                e = sb.pop_front();
                check("pulse_error", 64'(error), 64'(e.is_err));
                check("pulse_valid", 64'(data_valid), 64'(!e.is_err));
                check("data_out", 64'(data_out), 64'(e.data));
                check("chk_ok", 64'(chk_ok), 64'(e.chk));
                if (e.is_err) begin
                    check("err_code", 64'(err_code), 64'(e.code));
                    last_err_cyc = cyc;
                end
            end
        end
    end

    initial begin
        int          sc, idle_at, p0;
        logic [39:0] f5;
        bit          found;

        rst = 1'b0; start = 1'b0;
        sens_low = 1'b0; sens_high = 1'b0; sens_abort = 1'b0; cur_bit = -1;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_line", 64'(dht_line), 64'(1));
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_flags", 64'({data_valid, error, chk_ok, err_code}), 64'(0));
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();

        // good frame, with a start request issued while busy
        p0 = pulses;
        push_valid(40'h350018004D);
        start_txn(sc);
        fork
            sensor_txn(40'h350018004D, 40, 1'b1);
            begin
                repeat ($urandom_range(100, 20000)) tick();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        join
        wait_idle(5000, idle_at);
        check("start_pulse_len", 64'(last_run), 64'(START_US));
        check("single_start_pulse", 64'(pulses - p0), 64'(1));
        repeat ($urandom_range(1, 20)) tick();

        // bad checksum frame
        push_valid(40'h350018004C);
        start_txn(sc);
        sensor_txn(40'h350018004C, 40, 1'b1);
        wait_idle(5000, idle_at);
        check("scoreboard_drained_3", 64'(sb.size()), 64'(0));

        // silent sensor
        push_error(2'd1);
        last_err_cyc = -1;
        start_txn(sc);
        sensor_txn('0, 0, 1'b0);
        wait_idle(2000, idle_at);
        check("no_response_error_time", 64'(last_err_cyc), 64'(sc + START_US + RESP_TO));
        check("gap_busy_drop", 64'((idle_at - last_err_cyc) >= 10 && (idle_at - last_err_cyc) <= 12), 64'(1));

        // sensor stops after 20 bits, line left high
        f5 = {8'($urandom), 32'($urandom)};
        push_error(2'd3);
        start_txn(sc);
        sensor_txn(f5, 20, 1'b1);
        wait_idle(2000, idle_at);
        check("data_out_kept", 64'(data_out), 64'(40'h350018004C));

        // reset in the high phase of the tenth bit
        p0 = pulses;
        start_txn(sc);
        fork
            sensor_txn({8'($urandom), 32'($urandom)}, 40, 1'b1);
            begin
                found = 1'b0;
                for (int k = 0; k < START_US + 3000; k++) begin
                    tick();
                    if (cur_bit == 9 && sens_high) begin
                        found = 1'b1;
                        break;
                    end
                end
                check("reached_bit10", 64'(found), 64'(1));
                repeat ($urandom_range(1, 20)) tick();
                rst = 1'b0;
                #1;
                check("mid_rst_busy", 64'(busy), 64'(0));
                check("mid_rst_line", 64'(dht_line), 64'(1));
                check("mid_rst_data_out", 64'(data_out), 64'(0));
                check("mid_rst_flags", 64'({data_valid, error, chk_ok, err_code}), 64'(0));
                sens_abort = 1'b1;
            end
        join
        repeat (3) tick();
        rst        = 1'b1;
        sens_abort = 1'b0;
        repeat (200) tick();
        check("no_extra_pulse", 64'(pulses - p0), 64'(1));
        check("idle_after_rst", 64'({busy, dht_line}), 64'(2'b01));
        check("scoreboard_drained_end", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
